stopwatch_counter: RTL and testbench

Generates the 16-bit binary value consumed by the 4-digit seven-segment display driver, on its displayed_number input. Two raw push-buttons (start/stop, clear) are synchronised, debounced and edge-detected. A run/pause state machine gates a prescaled tick that increments a 0..MAX_COUNT counter. With default parameters the block is a 0.01 s stopwatch showing 00.00–99.99 at 100 MHz.

---
 rtl/stopwatch_counter.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_counter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: debounced start/stop and clear buttons drive a
// run/pause FSM that counts prescaled ticks from 0 up to MAX_COUNT.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV        = 1_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_COUNT       = 9999,
    parameter bit          WRAP            = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] displayed_number,
    output logic        running,
    output logic        overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [13:0]   CNT_MAX   = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // bit 0 = start/stop, bit 1 = clear
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] stable_q;
    logic [1:0] stable_d;
    logic [1:0] prev_q;
    logic [1:0] armed_q;
    logic [1:0] live_q;
    logic [1:0] press;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    assign btn_raw = {btn_clear, btn_start_stop};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // A button must be seen released after reset before it may fire,
    // so a button held through reset stays silent until re-pressed.
    assign press = stable_q & ~prev_q & armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            armed_q  <= '0;
            live_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            live_q   <= {live_q[0], 1'b1};
            armed_q  <= armed_q | ({2{live_q[1]}} & ~sync2_q);
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [13:0]   count_q;
    logic [13:0]   count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          run_q;
    logic          ss_ev;
    logic          clr_ev;
    logic          tick;

    assign ss_ev  = press[0];
    assign clr_ev = press[1];
    assign tick   = (state_q == RUN) && (presc_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_ev) begin
            state_d = IDLE;
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ss_ev) state_d = RUN;
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                        if (count_q < CNT_MAX) begin
                            count_d = count_q + 14'd1;
                        end else begin
                            ovf_d = 1'b1;
                            if (WRAP) count_d = '0;
                            else      state_d = PAUSE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    // tick increment stands; a pause press still wins the state
                    if (ss_ev) state_d = PAUSE;
                end
                PAUSE: begin
                    if (ss_ev) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == RUN);
        end
    end

    assign displayed_number = {2'b00, count_q};
    assign running          = run_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: scheduled button events feed a
// cycle-level behavioural stopwatch model compared against two DUTs.
module tb_stopwatch_counter;

    localparam int TD  = 4;
    localparam int DB  = 3;
    localparam int MX  = 12;
    localparam int LAT = 3 + DB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss0 = 1'b0, clr0 = 1'b0;
    logic ss1 = 1'b0, clr1 = 1'b0;
    logic [15:0] dn0, dn1;
    logic run0, run1, ovf0, ovf1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    bit ss_at0 [16384];
    bit clr_at0 [16384];
    bit ss_at1 [16384];
    bit clr_at1 [16384];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stopwatch_counter #(
        .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .MAX_COUNT(MX), .WRAP(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .btn_start_stop(ss0), .btn_clear(clr0),
        .displayed_number(dn0), .running(run0), .overflow(ovf0)
    );

    stopwatch_counter #(
        .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .MAX_COUNT(MX), .WRAP(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .btn_start_stop(ss1), .btn_clear(clr1),
        .displayed_number(dn1), .running(run1), .overflow(ovf1)
    );

    // st: 0 idle, 1 run, 2 pause; acc = run cycles since last tick
    typedef struct packed {
        logic [1:0] st;
        int         count;
        logic       ovf;
        int         acc;
    } m_t;

    m_t m0, m1;

    function automatic m_t mstep(m_t m, bit ss, bit clr, bit wrap);
        m_t n;
        n = m;
        if (clr) begin
            n = '0;
        end else begin
            if (m.st == 2'd1) begin
                n.acc = m.acc + 1;
                if (n.acc == TD) begin
                    n.acc = 0;
                    if (m.count < MX) begin
                        n.count = m.count + 1;
                    end else begin
                        n.ovf = 1'b1;
                        if (wrap) n.count = 0;
                        else n.st = 2'd2;
                    end
                end
            end
            if (ss) n.st = (m.st == 2'd1) ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

    function automatic logic [17:0] expv(m_t m);
        return {16'(m.count), (m.st == 2'd1), m.ovf};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '0;
            m1 <= '0;
        end else begin
            m0 <= mstep(m0, ss_at0[cyc+1], clr_at0[cyc+1], 1'b0);
            m1 <= mstep(m1, ss_at1[cyc+1], clr_at1[cyc+1], 1'b1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean press (hold >= DB); its event lands LAT edges later.
    task automatic launch(input bit d, input bit ss, input bit clr,
                          input int hold);
        int at;
        at = cyc + LAT;
        if (d == 1'b0) begin
            ss0 = ss;
            clr0 = clr;
            if (ss) ss_at0[at] = 1'b1;
            if (clr) clr_at0[at] = 1'b1;
        end else begin
            ss1 = ss;
            clr1 = clr;
            if (ss) ss_at1[at] = 1'b1;
            if (clr) clr_at1[at] = 1'b1;
        end
        step(hold);
        ss0 = 1'b0; clr0 = 1'b0;
        ss1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic test_reset;
        step(3);
        total++;
        if ({dn0, run0, ovf0} !== 18'd0 || {dn1, run1, ovf1} !== 18'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h/%h want=0", {dn0, run0, ovf0},
                     {dn1, run1, ovf1});
        end
        rst_n = 1'b1;
        step(6);
        total++;
        if ({dn0, run0, ovf0} !== expv(m0) || {dn0, run0, ovf0} !== 18'd0) begin
            bad++;
            $display("FAIL reset_release got=%h want=0", {dn0, run0, ovf0});
        end
    endtask

    task automatic test_debounce;
        ss0 = 1'b1;
        step(2);
        ss0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0) || run0 !== 1'b0) begin
                bad++;
                $display("FAIL glitch cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        launch(0, 1, 0, 4);
        step(1);
        total++;
        if (run0 !== 1'b0) begin
            bad++;
            $display("FAIL db_edge5 got=%b want=0", run0);
        end
        step(1);
        total++;
        if (run0 !== 1'b1) begin
            bad++;
            $display("FAIL db_edge6 got=%b want=1", run0);
        end
    endtask

    task automatic test_counting;
        launch(0, 0, 1, 4);
        step(8);
        launch(0, 1, 0, 4);
        for (int k = 0; k < 22; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL count_run cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        total++;
        if (dn0 !== 16'd5 || run0 !== 1'b1) begin
            bad++;
            $display("FAIL count_20 got=%0d/%b want=5/1", dn0, run0);
        end
        launch(0, 1, 0, 4);
        for (int k = 0; k < 10; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL count_pause cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        total++;
        if (dn0 !== 16'd6 || run0 !== 1'b0) begin
            bad++;
            $display("FAIL frozen got=%0d/%b want=6/0", dn0, run0);
        end
        launch(0, 1, 0, 4);
        step(3);
        total++;
        if (dn0 !== 16'd6 || run0 !== 1'b1) begin
            bad++;
            $display("FAIL resume got=%0d/%b want=6/1", dn0, run0);
        end
        step(1);
        total++;
        if (dn0 !== 16'd7) begin
            bad++;
            $display("FAIL phase_kept got=%0d want=7", dn0);
        end
    endtask

    task automatic test_saturation;
        launch(0, 0, 1, 4);
        step(8);
        launch(0, 1, 0, 4);
        for (int k = 0; k < 54; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL sat_run cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        total++;
        if (dn0 !== 16'd12 || ovf0 !== 1'b1 || run0 !== 1'b0) begin
            bad++;
            $display("FAIL saturate got=%0d/%b/%b want=12/1/0", dn0, ovf0, run0);
        end
        launch(0, 1, 0, 4);
        for (int k = 0; k < 8; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL sat_again cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        total++;
        if (dn0 !== 16'd12 || ovf0 !== 1'b1 || run0 !== 1'b0) begin
            bad++;
            $display("FAIL repause got=%0d/%b/%b want=12/1/0", dn0, ovf0, run0);
        end
    endtask

    task automatic test_wrap;
        launch(1, 1, 0, 4);
        for (int k = 0; k < 54; k++) begin
            step(1);
            total++;
            if ({dn1, run1, ovf1} !== expv(m1)) begin
                bad++;
                $display("FAIL wrap_run cyc=%0d got=%h want=%h", cyc,
                         {dn1, run1, ovf1}, expv(m1));
            end
        end
        total++;
        if (dn1 !== 16'd0 || ovf1 !== 1'b1 || run1 !== 1'b1) begin
            bad++;
            $display("FAIL wrap got=%0d/%b/%b want=0/1/1", dn1, ovf1, run1);
        end
    endtask

    task automatic test_clear_priority;
        launch(0, 0, 1, 4);
        step(8);
        launch(0, 1, 0, 4);
        for (int k = 0; k < 35; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL clrp_run cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        launch(0, 1, 1, 4);
        step(1);
        total++;
        if (dn0 !== 16'd9 || run0 !== 1'b1) begin
            bad++;
            $display("FAIL clrp_pre got=%0d/%b want=9/1", dn0, run0);
        end
        step(1);
        total++;
        if (dn0 !== 16'd0 || run0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL clr_wins got=%0d/%b/%b want=0/0/0", dn0, run0, ovf0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0) || dn0 !== 16'd0) begin
                bad++;
                $display("FAIL clr_idle cyc=%0d got=%h want=0", cyc,
                         {dn0, run0, ovf0});
            end
        end
    endtask

    task automatic test_tick_pause;
        launch(0, 0, 1, 4);
        step(8);
        launch(0, 1, 0, 4);
        for (int k = 0; k < 12; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL tp_run cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        launch(0, 1, 0, 4);
        step(1);
        total++;
        if (dn0 !== 16'd3 || run0 !== 1'b1) begin
            bad++;
            $display("FAIL tp_pre got=%0d/%b want=3/1", dn0, run0);
        end
        step(1);
        total++;
        if (dn0 !== 16'd4 || run0 !== 1'b0) begin
            bad++;
            $display("FAIL tick_pause got=%0d/%b want=4/0", dn0, run0);
        end
        for (int k = 0; k < 6; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0) || dn0 !== 16'd4) begin
                bad++;
                $display("FAIL tp_hold cyc=%0d got=%h want=4", cyc,
                         {dn0, run0, ovf0});
            end
        end
    endtask

    task automatic test_async_reset;
        launch(0, 0, 1, 4);
        step(8);
        launch(0, 1, 0, 4);
        for (int k = 0; k < 31; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0)) begin
                bad++;
                $display("FAIL ar_run cyc=%0d got=%h want=%h", cyc,
                         {dn0, run0, ovf0}, expv(m0));
            end
        end
        total++;
        if (dn0 !== 16'd7) begin
            bad++;
            $display("FAIL ar_pre got=%0d want=7", dn0);
        end
        #2;
        rst_n = 1'b0;
        ss0 = 1'b1;
        #1;
        total++;
        if (dn0 !== 16'd0 || run0 !== 1'b0 || ovf0 !== 1'b0) begin
            bad++;
            $display("FAIL async_rst got=%0d/%b/%b want=0/0/0", dn0, run0, ovf0);
        end
        step(3);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            total++;
            if ({dn0, run0, ovf0} !== expv(m0) || run0 !== 1'b0) begin
                bad++;
                $display("FAIL held_btn cyc=%0d got=%h want=0", cyc,
                         {dn0, run0, ovf0});
            end
        end
        ss0 = 1'b0;
        step(12);
        launch(0, 1, 0, 4);
        step(1);
        total++;
        if (run0 !== 1'b0) begin
            bad++;
            $display("FAIL repress5 got=%b want=0", run0);
        end
        step(1);
        total++;
        if (run0 !== 1'b1 || {dn0, run0, ovf0} !== expv(m0)) begin
            bad++;
            $display("FAIL repress6 got=%h want=%h", {dn0, run0, ovf0},
                     expv(m0));
        end
    endtask

    task automatic test_random;
        int r, h, g, gap;
        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 99);
            h = $urandom_range(3, 6);
            if (r < 55) begin
                launch(0, 1, 0, h);
            end else if (r < 70) begin
                launch(0, 0, 1, h);
            end else if (r < 80) begin
                launch(0, 1, 1, h);
            end else begin
                g = $urandom_range(1, 2);
                if (r < 90) ss0 = 1'b1;
                else clr0 = 1'b1;
                step(g);
                ss0 = 1'b0;
                clr0 = 1'b0;
            end
            gap = $urandom_range(8, 26);
            for (int k = 0; k < gap; k++) begin
                step(1);
                total++;
                if ({dn0, run0, ovf0} !== expv(m0)) begin
                    bad++;
                    $display("FAIL rnd0 cyc=%0d got=%h want=%h", cyc,
                             {dn0, run0, ovf0}, expv(m0));
                end
                total++;
                if ({dn1, run1, ovf1} !== expv(m1)) begin
                    bad++;
                    $display("FAIL rnd1 cyc=%0d got=%h want=%h", cyc,
                             {dn1, run1, ovf1}, expv(m1));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_counting;
        test_saturation;
        test_wrap;
        test_clear_priority;
        test_tick_pause;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
